// File: rtl/seg7_scan_driver.sv
// Multiplexed hex 7-segment scan driver with refresh prescaler, double-buffered load,
// frame-aligned shadow update, leading-zero blanking and an anode guard after each digit switch.
// Optional feature: define SEG7_BLINK_EN to add a 24-bit blink counter and per-digit blink mask.
// All display outputs (HEX, AN, pend_o) are registered; frame_o is decoded from registered state.

module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD_CYC   = 2,
  parameter int unsigned LZ_BLANK    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   en_i,
  input  logic [NUM_DIGITS-1:0]   blink_i,
  output logic [7:0]              HEX,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic                    pend_o,
  output logic                    frame_o
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CntW-1:0] CntLast  = CntW'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_DIGITS - 1);
  localparam logic [CntW-1:0] GuardLen = CntW'(GUARD_CYC);

  typedef logic [NUM_DIGITS-1:0][3:0] nib_arr_t;

  // Hex nibble to active-low g..a segments; bit 7 (dp) left dark here.
  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] seg;
    unique case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
    endcase
    return seg;
  endfunction

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  pend_q, pend_d;
  nib_arr_t              pval_q, pval_d, sval_q, sval_d;
  logic [NUM_DIGITS-1:0] pdp_q, pdp_d, sdp_q, sdp_d;
  logic [NUM_DIGITS-1:0] pen_q, pen_d, sen_q, sen_d;
  logic [7:0]            hex_q, hex_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic                  tick, wrap;
  logic [NUM_DIGITS-1:0] zero_dig, lz_blank;
  logic                  lz_run;
  logic                  blink_dark;
  logic                  visible;
  logic                  guard;
  logic [7:0]            glyph;

  assign tick    = (cnt_q == CntLast);
  assign wrap    = tick && (idx_q == IdxLast);
  // Wrap is decoded from registered counters, so the pulse lands in the wrap-tick cycle.
  assign frame_o = wrap;
  assign HEX     = hex_q;
  assign AN      = an_q;
  assign pend_o  = pend_q;

  // Prescaler and scan index next state.
  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    idx_d = idx_q;
    if (tick) begin
      cnt_d = '0;
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
    end
  end

  // Pending buffer captures loads; shadow only changes on the frame wrap so a frame never tears.
  always_comb begin
    pval_d = pval_q;
    pdp_d  = pdp_q;
    pen_d  = pen_q;
    pend_d = pend_q;
    sval_d = sval_q;
    sdp_d  = sdp_q;
    sen_d  = sen_q;
    if (load_i) begin
      pval_d = value_i;
      pdp_d  = dp_i;
      pen_d  = en_i;
      pend_d = 1'b1;
    end
    if (wrap) begin
      // A load landing on the wrap tick bypasses pending and is never reported as pending.
      sval_d = load_i ? nib_arr_t'(value_i) : pval_q;
      sdp_d  = load_i ? dp_i : pdp_q;
      sen_d  = load_i ? en_i : pen_q;
      pend_d = 1'b0;
    end
  end

  // Leading-zero blanking walks down from the top digit; disabled digits count as zero.
  always_comb begin
    lz_run   = 1'b1;
    lz_blank = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      zero_dig[k] = (sval_d[k] == 4'h0) || !sen_d[k];
    end
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      lz_run      = lz_run & zero_dig[k];
      lz_blank[k] = lz_run & (LZ_BLANK != 0);
    end
  end

`ifdef SEG7_BLINK_EN
  logic [NUM_DIGITS-1:0] pblk_q, pblk_d, sblk_q, sblk_d;
  logic [23:0]           blink_cnt_q;

  // Blink mask follows the same pending/shadow path as the other digit attributes.
  always_comb begin
    pblk_d = pblk_q;
    sblk_d = sblk_q;
    if (load_i) begin
      pblk_d = blink_i;
    end
    if (wrap) begin
      sblk_d = load_i ? blink_i : pblk_q;
    end
  end

  // Free-running blink phase counter plus blink buffers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      pblk_q      <= '0;
      sblk_q      <= '0;
    end else begin
      blink_cnt_q <= blink_cnt_q + 24'd1;
      pblk_q      <= pblk_d;
      sblk_q      <= sblk_d;
    end
  end

  assign blink_dark = sblk_d[idx_d] & blink_cnt_q[23];
`else
  logic unused_blink;
  assign unused_blink = ^blink_i;
  assign blink_dark   = 1'b0;
`endif

  // Output glyph and anode pattern for the slot the scan is about to show.
  always_comb begin
    glyph   = seg_decode(sval_d[idx_d]);
    visible = sen_d[idx_d] && !lz_blank[idx_d] && !blink_dark;
    guard   = (cnt_d < GuardLen);
    hex_d   = 8'hFF;
    an_d    = '1;
    if (visible) begin
      hex_d = {~sdp_d[idx_d], glyph[6:0]};
      if (!guard) begin
        an_d[idx_d] = 1'b0;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      pend_q <= 1'b0;
      pval_q <= '0;
      pdp_q  <= '0;
      pen_q  <= '0;
      sval_q <= '0;
      sdp_q  <= '0;
      sen_q  <= '0;
      hex_q  <= 8'hFF;
      an_q   <= '1;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      pval_q <= pval_d;
      pdp_q  <= pdp_d;
      pen_q  <= pen_d;
      sval_q <= sval_d;
      sdp_q  <= sdp_d;
      sen_q  <= sen_d;
      hex_q  <= hex_d;
      an_q   <= an_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: two instances (leading-zero blanking on and off) share
// the same stimulus; every cycle of selected frames is checked against hand-computed glyphs.

module tb_seg7_scan_driver;

  logic        clk;
  logic        rst;
  logic        load_i;
  logic [15:0] value_i;
  logic [3:0]  dp_i;
  logic [3:0]  en_i;
  logic [3:0]  blink_i;

  logic [7:0]  hex_lz, hex_nl;
  logic [3:0]  an_lz, an_nl;
  logic        pend_lz, pend_nl;
  logic        frame_lz, frame_nl;

  int n_vec;
  int n_err;

  // Load values applied inside check_frame.
  logic [15:0] ld_val, ld2_val;
  logic [3:0]  ld_dp, ld2_dp, ld_en, ld2_en;

  seg7_scan_driver #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(4),
    .GUARD_CYC  (1),
    .LZ_BLANK   (1)
  ) u_lz (
    .clk    (clk),
    .rst    (rst),
    .load_i (load_i),
    .value_i(value_i),
    .dp_i   (dp_i),
    .en_i   (en_i),
    .blink_i(blink_i),
    .HEX    (hex_lz),
    .AN     (an_lz),
    .pend_o (pend_lz),
    .frame_o(frame_lz)
  );

  seg7_scan_driver #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(4),
    .GUARD_CYC  (1),
    .LZ_BLANK   (0)
  ) u_nl (
    .clk    (clk),
    .rst    (rst),
    .load_i (load_i),
    .value_i(value_i),
    .dp_i   (dp_i),
    .en_i   (en_i),
    .blink_i(blink_i),
    .HEX    (hex_nl),
    .AN     (an_nl),
    .pend_o (pend_nl),
    .frame_o(frame_nl)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_hex_lz"}, 32'(hex_lz), 32'hFF);
    check({tag, "_an_lz"}, 32'(an_lz), 32'hF);
    check({tag, "_pend_lz"}, 32'(pend_lz), 32'h0);
    check({tag, "_frame_lz"}, 32'(frame_lz), 32'h0);
    check({tag, "_hex_nl"}, 32'(hex_nl), 32'hFF);
    check({tag, "_an_nl"}, 32'(an_nl), 32'hF);
    check({tag, "_pend_nl"}, 32'(pend_nl), 32'h0);
    check({tag, "_frame_nl"}, 32'(frame_nl), 32'h0);
  endtask

  // Advance until the wrap-tick cycle, then across it, so the next frame starts at slot 0.
  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    while (frame_lz !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check({tag, "_sync"}, 32'(frame_lz), 32'h1);
    step();
  endtask

  // Checks all 16 cycles of one frame starting right after the wrap tick. Expected words hold
  // digit3..digit0 from MSB to LSB. An optional load (and a second back-to-back load) is driven.
  task automatic check_frame(input string tag,
                             input logic [3:0][7:0] lz_hex, input logic [3:0][3:0] lz_an,
                             input logic [3:0][7:0] nl_hex, input logic [3:0][3:0] nl_an,
                             input int load_at, input bit dbl);
    for (int i = 0; i < 16; i++) begin
      int s;
      int c;
      string t;
      s = i / 4;
      c = i % 4;
      t = $sformatf("%s_c%0d", tag, i);
      load_i = 1'b0;
      check({t, "_hex_lz"}, 32'(hex_lz), 32'(lz_hex[s]));
      check({t, "_an_lz"}, 32'(an_lz), (c == 0) ? 32'hF : 32'(lz_an[s]));
      check({t, "_hex_nl"}, 32'(hex_nl), 32'(nl_hex[s]));
      check({t, "_an_nl"}, 32'(an_nl), (c == 0) ? 32'hF : 32'(nl_an[s]));
      check({t, "_pend_lz"}, 32'(pend_lz), (load_at >= 0 && i > load_at) ? 32'h1 : 32'h0);
      check({t, "_pend_nl"}, 32'(pend_nl), (load_at >= 0 && i > load_at) ? 32'h1 : 32'h0);
      check({t, "_frame_lz"}, 32'(frame_lz), (i == 15) ? 32'h1 : 32'h0);
      check({t, "_frame_nl"}, 32'(frame_nl), (i == 15) ? 32'h1 : 32'h0);
      if (i == load_at) begin
        load_i  = 1'b1;
        value_i = ld_val;
        dp_i    = ld_dp;
        en_i    = ld_en;
      end else if (dbl && i == load_at + 1) begin
        load_i  = 1'b1;
        value_i = ld2_val;
        dp_i    = ld2_dp;
        en_i    = ld2_en;
      end
      step();
    end
    load_i = 1'b0;
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b1;
    load_i  = 1'b0;
    value_i = '0;
    dp_i    = '0;
    en_i    = '0;
    blink_i = '0;
    ld_val  = '0;
    ld_dp   = '0;
    ld_en   = '0;
    ld2_val = '0;
    ld2_dp  = '0;
    ld2_en  = '0;

    #3;
    check_idle_outputs("reset");
    #19;
    rst = 1'b0;
    step();

    // Nothing loaded yet: display stays dark.
    for (int i = 0; i < 6; i++) begin
      check($sformatf("dark%0d_hex", i), 32'(hex_lz), 32'hFF);
      check($sformatf("dark%0d_an", i), 32'(an_lz), 32'hF);
      step();
    end

    wait_frame("f0");

    // Frame 0: still dark; mid-frame load of 0003.
    ld_val = 16'h0003; ld_dp = 4'b0000; ld_en = 4'b1111;
    check_frame("f0", 32'hFFFF_FFFF, 16'hFFFF, 32'hFFFF_FFFF, 16'hFFFF, 5, 1'b0);

    // Frame 1: 0003 shown; mid-frame load of A0b5 must not tear this frame.
    ld_val = 16'hA0B5; ld_dp = 4'b0000; ld_en = 4'b1111;
    check_frame("f1", 32'hFFFF_FFB0, 16'hFFFE, 32'hC0C0_C0B0, 16'h7BDE, 7, 1'b0);

    // Frame 2: A0b5 shown; load coincident with the wrap tick.
    ld_val = 16'h0070; ld_dp = 4'b0100; ld_en = 4'b1111;
    check_frame("f2", 32'h88C0_8392, 16'h7BDE, 32'h88C0_8392, 16'h7BDE, 15, 1'b0);

    // Frame 3: 0070 with dp on digit 2 (blanked in the LZ instance); back-to-back loads.
    ld_val  = 16'h1111; ld_dp  = 4'b1111; ld_en  = 4'b1111;
    ld2_val = 16'h0305; ld2_dp = 4'b0000; ld2_en = 4'b1011;
    check_frame("f3", 32'hFFFF_F8C0, 16'hFFDE, 32'hC040_F8C0, 16'h7BDE, 10, 1'b1);

    // Frame 4: last load wins; disabled digit 2 counts as zero for blanking.
    check_frame("f4", 32'hFFFF_FF92, 16'hFFFE, 32'hC0FF_C092, 16'h7FDE, -1, 1'b0);

    // Reset in the middle of a slot with a load pending.
    value_i = 16'h1234;
    en_i    = 4'b1111;
    load_i  = 1'b1;
    step();
    load_i = 1'b0;
    check("mid_pend", 32'(pend_lz), 32'h1);
    step();
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    step();
    step();
    rst = 1'b0;

    wait_frame("f5");
    check_frame("f5", 32'hFFFF_FFFF, 16'hFFFF, 32'hFFFF_FFFF, 16'hFFFF, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
